// File: rtl/aes_host_sequencer.sv
// Host-side sequencer for the byte-serial aescipher command port: it streams the plaintext and
// key in as SP/SK bytes, issues ST, collects 16 result bytes and returns them on a response channel.
module aes_host_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [127:0] i_req_text,
    input  logic [127:0] i_req_key,
    input  logic         i_req_key_reuse,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [127:0] o_rsp_data,
    output logic         o_rsp_timeout,
    output logic [1:0]   o_aes_cmd,
    output logic [7:0]   o_aes_din,
    input  logic         i_aes_ready,
    input  logic         i_aes_ok,
    input  logic [7:0]   i_aes_dout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] CmdId = 2'b00;
    localparam logic [1:0] CmdSt = 2'b01;
    localparam logic [1:0] CmdSk = 2'b10;
    localparam logic [1:0] CmdSp = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StLoadPt,
        StGap1,
        StLoadKey,
        StGap2,
        StStart,
        StWaitOk,
        StCapture,
        StResp
    } state_e;

    state_e           r_state;
    logic [127:0]     r_text;
    logic [127:0]     r_key;
    logic             r_reuse;
    logic             r_key_loaded;
    logic [3:0]       r_byte_cnt;
    logic [CntW-1:0]  r_wait_cnt;
    logic             r_rsp_valid;
    logic [127:0]     r_rsp_data;
    logic             r_rsp_timeout;
    logic [1:0]       r_cmd;
    logic [7:0]       r_din;

    logic [3:0]       w_next_cnt;
    logic [6:0]       w_next_bit;
    logic [6:0]       w_cur_bit;

    assign w_next_cnt = r_byte_cnt + 4'd1;
    assign w_next_bit = {w_next_cnt, 3'b000};
    assign w_cur_bit  = {r_byte_cnt, 3'b000};

    assign o_req_ready   = (r_state == StIdle) && !i_rst;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_aes_cmd     = r_cmd;
    assign o_aes_din     = r_din;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_text        <= '0;
            r_key         <= '0;
            r_reuse       <= 1'b0;
            r_key_loaded  <= 1'b0;
            r_byte_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_cmd         <= CmdId;
            r_din         <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_text        <= i_req_text;
                        r_key         <= i_req_key;
                        r_reuse       <= i_req_key_reuse && r_key_loaded;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_byte_cnt    <= '0;
                        r_cmd         <= CmdSp;
                        r_din         <= i_req_text[7:0];
                        r_state       <= StLoadPt;
                    end
                end
                StLoadPt: begin
                    if (r_byte_cnt == 4'd15) begin
                        r_cmd   <= CmdId;
                        r_din   <= '0;
                        r_state <= StGap1;
                    end else begin
                        r_byte_cnt <= w_next_cnt;
                        r_din      <= r_text[w_next_bit +: 8];
                    end
                end
                StGap1: begin
                    r_byte_cnt <= '0;
                    if (r_reuse) begin
                        // ST is registered, so the ready sampled here gates the very next cycle
                        r_cmd   <= i_aes_ready ? CmdSt : CmdId;
                        r_state <= StStart;
                    end else begin
                        r_cmd   <= CmdSk;
                        r_din   <= r_key[7:0];
                        r_state <= StLoadKey;
                    end
                end
                StLoadKey: begin
                    if (r_byte_cnt == 4'd15) begin
                        r_key_loaded <= 1'b1;
                        r_cmd        <= CmdId;
                        r_din        <= '0;
                        r_state      <= StGap2;
                    end else begin
                        r_byte_cnt <= w_next_cnt;
                        r_din      <= r_key[w_next_bit +: 8];
                    end
                end
                StGap2: begin
                    r_cmd   <= i_aes_ready ? CmdSt : CmdId;
                    r_state <= StStart;
                end
                StStart: begin
                    if (r_cmd == CmdSt) begin
                        r_cmd      <= CmdId;
                        r_wait_cnt <= '0;
                        r_state    <= StWaitOk;
                    end else if (i_aes_ready) begin
                        r_cmd <= CmdSt;
                    end
                end
                StWaitOk: begin
                    if (i_aes_ok) begin
                        r_rsp_data[7:0] <= i_aes_dout;
                        r_byte_cnt      <= 4'd1;
                        r_state         <= StCapture;
                    end else if (r_wait_cnt == CntW'(TIMEOUT_CYCLES)) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= StResp;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StCapture: begin
                    r_rsp_data[w_cur_bit +: 8] <= i_aes_dout;
                    if (r_byte_cnt == 4'd15) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_byte_cnt <= w_next_cnt;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Self-checking bench for aes_host_sequencer: a cycle-exact cipher stand-in drives the port,
// expected responses are queued at request time and compared when the response appears.
module tb_aes_host_sequencer;

    localparam int TO = 16;
    localparam logic [1:0] CmdId = 2'b00;
    localparam logic [1:0] CmdSt = 2'b01;
    localparam logic [1:0] CmdSk = 2'b10;
    localparam logic [1:0] CmdSp = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_text;
    logic [127:0] req_key;
    logic         req_key_reuse;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_timeout;
    logic [1:0]   aes_cmd;
    logic [7:0]   aes_din;
    logic         aes_ready;
    logic         aes_ok;
    logic [7:0]   aes_dout;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_data[$];
    logic         sb_to[$];

    aes_host_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_text     (req_text),
        .i_req_key      (req_key),
        .i_req_key_reuse(req_key_reuse),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_timeout  (rsp_timeout),
        .o_aes_cmd      (aes_cmd),
        .o_aes_din      (aes_din),
        .i_aes_ready    (aes_ready),
        .i_aes_ok       (aes_ok),
        .i_aes_dout     (aes_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running exp finished");
        $fatal(1, "watchdog");
    end

    // Called at a negedge with the DUT idle. Cycle c is the c-th cycle after the accept edge;
    // outputs are sampled and next inputs driven at each negedge.
    task automatic run_txn(input string name, input logic [127:0] text, input logic [127:0] key,
                           input bit reuse, input bit exp_full, input int rdy_low,
                           input int ok_lat, input logic [127:0] ct, input int hold);
        int base, est, t_ok, rv, last;
        logic [1:0] ecmd;
        logic [7:0] edin;
        logic [127:0] exp_d;
        logic exp_to;
        base = exp_full ? 35 : 18;
        est  = base + rdy_low;
        if (ok_lat >= 0) begin
            t_ok = est + ok_lat;
            rv   = t_ok + 16;
        end else begin
            t_ok = -100;
            rv   = est + TO + 2;
        end
        last  = rv + hold + 1;
        exp_d = '0;
        exp_to = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready: got %b exp 1", name, req_ready);
        end
        req_valid     = 1'b1;
        req_text      = text;
        req_key       = key;
        req_key_reuse = reuse;
        sb_data.push_back((ok_lat >= 0) ? ct : 128'h0);
        sb_to.push_back(ok_lat < 0);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid     = 1'b0;
                req_text      = {4{$urandom}};
                req_key       = {4{$urandom}};
                req_key_reuse = ~reuse;
            end
            ecmd = CmdId;
            edin = 8'h00;
            if (c <= 16) begin
                ecmd = CmdSp;
                edin = text[8*(c-1) +: 8];
            end else if (exp_full && c >= 18 && c <= 33) begin
                ecmd = CmdSk;
                edin = key[8*(c-18) +: 8];
            end else if (c == est) begin
                ecmd = CmdSt;
            end
            checks++;
            if (aes_cmd !== ecmd || aes_din !== edin) begin
                errors++;
                $display("FAIL %s cmd_din c=%0d: got %0d/%02h exp %0d/%02h",
                         name, c, aes_cmd, aes_din, ecmd, edin);
            end
            if (c < rv) begin
                checks++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy c=%0d: got rsp_valid=%b req_ready=%b exp 0/0",
                             name, c, rsp_valid, req_ready);
                end
            end else if (c == rv) begin
                exp_d  = sb_data.pop_front();
                exp_to = sb_to.pop_front();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_timeout !== exp_to) begin
                    errors++;
                    $display("FAIL %s response c=%0d: got v=%b d=%h to=%b exp v=1 d=%h to=%b",
                             name, c, rsp_valid, rsp_data, rsp_timeout, exp_d, exp_to);
                end
            end else if (c < last) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_timeout !== exp_to ||
                    req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s held c=%0d: got v=%b d=%h to=%b rr=%b exp v=1 d=%h to=%b rr=0",
                             name, c, rsp_valid, rsp_data, rsp_timeout, req_ready, exp_d, exp_to);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s after_handshake: got v=%b rr=%b exp v=0 rr=1",
                             name, rsp_valid, req_ready);
                end
            end
            aes_ready = !(c >= base - 1 && c < base - 1 + rdy_low);
            if (ok_lat >= 0 && c >= t_ok && c <= t_ok + 15) begin
                aes_dout = ct[8*(c-t_ok) +: 8];
                // second strobe mid-capture must not restart collection
                aes_ok   = (c == t_ok) || (c == t_ok + 5);
            end else begin
                aes_dout = 8'($urandom);
                aes_ok   = (ok_lat >= 0) && (c == 10);
            end
            rsp_ready = (c == rv + hold);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 ||
            rsp_data !== 128'h0 || aes_cmd !== CmdId || aes_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got rr=%b v=%b to=%b d=%h cmd=%0d din=%02h exp all 0",
                     req_ready, rsp_valid, rsp_timeout, rsp_data, aes_cmd, aes_din);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got req_ready=%b exp 1", req_ready);
        end
    endtask

    task automatic test_reuse_after_reset();
        run_txn("reuse_after_reset", 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                128'h13579bdf02468ace1122334455667788, 1'b1, 1'b1, 0, 4,
                128'hdeadbeef0123456789abcdeffedcba98, 2);
    endtask

    task automatic test_fips();
        run_txn("fips197", 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1, 0, 3,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    endtask

    task automatic test_back_to_back_reuse();
        run_txn("key_reuse", 128'ha5a55a5a0102030405060708090a0b0c,
                128'hffffffffffffffffffffffffffffffff, 1'b1, 1'b0, 0, 2,
                128'h0badf00dcafebabe1234567890abcdef, 0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 128'h1111222233334444555566667777888a,
                128'h0, 1'b1, 1'b0, 0, -1, 128'h0, 3);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 128'hfedcba98765432100123456789abcdef,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, 5, 6,
                128'h3925841d02dc09fbdc118597196a0b32, 10);
    endtask

    task automatic test_reset_mid();
        logic [127:0] text;
        logic [127:0] key;
        logic [1:0] ecmd;
        logic [7:0] edin;
        text = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
        key  = 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid accept_ready: got %b exp 1", req_ready);
        end
        req_valid     = 1'b1;
        req_text      = text;
        req_key       = key;
        req_key_reuse = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ecmd = (c <= 16) ? CmdSp : (c >= 18) ? CmdSk : CmdId;
            edin = (c <= 16) ? text[8*(c-1) +: 8] : (c >= 18) ? key[8*(c-18) +: 8] : 8'h00;
            checks++;
            if (aes_cmd !== ecmd || aes_din !== edin) begin
                errors++;
                $display("FAIL reset_mid load c=%0d: got %0d/%02h exp %0d/%02h",
                         c, aes_cmd, aes_din, ecmd, edin);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (aes_cmd !== CmdId || aes_din !== 8'h00 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid abort: got cmd=%0d din=%02h rr=%b v=%b exp 0/00/0/0",
                     aes_cmd, aes_din, req_ready, rsp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || aes_cmd !== CmdId) begin
            errors++;
            $display("FAIL reset_mid idle: got rr=%b cmd=%0d exp 1/0", req_ready, aes_cmd);
        end
        run_txn("reuse_after_midreset", 128'h00000000ffffffff00000000ffffffff,
                128'h0123456789abcdef0123456789abcdef, 1'b1, 1'b1, 0, 1,
                128'h5555aaaa5555aaaa5555aaaa5555aaaa, 1);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_text      = '0;
        req_key       = '0;
        req_key_reuse = 1'b0;
        rsp_ready     = 1'b0;
        aes_ready     = 1'b1;
        aes_ok        = 1'b0;
        aes_dout      = 8'h00;
        test_reset();
        test_reuse_after_reset();
        test_fips();
        test_back_to_back_reuse();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_host_sequencer.md
# aes_host_sequencer

Host-side command sequencer for the byte-serial `aescipher` command port. It accepts a 128-bit plaintext/key request on a valid/ready handshake and streams it into the cipher with `CMD_SP`/`CMD_SK` bytes. It then issues `CMD_ST`, waits for `ok`, collects the 16 ciphertext bytes from `dout`, and returns the 128-bit result on a valid/ready response channel. It sits between a host/test controller and `aescipher`, driving the cipher's `din`/`cmd` inputs.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT_OK cycles before aborting (≥1).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_text` in 128: plaintext; byte k = bits[8k+7:8k].
- `req_key` in 128: key, same byte order as `req_text`.
- `req_key_reuse` in 1: skip key load if a key has been loaded since reset.
- `rsp_valid` out 1: response valid; held until `rsp_ready`.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out 128: ciphertext; byte k = k-th `dout` byte captured.
- `rsp_timeout` out 1: response is a timeout abort; `rsp_data` = 0.
- `aes_cmd` out 2: cipher command; ID=00, ST=01, SK=10, SP=11.
- `aes_din` out 8: cipher data byte.
- `aes_ready` in 1: cipher idle, able to take `CMD_ST`.
- `aes_ok` in 1: cipher result strobe; high on the cycle `dout` carries byte 0.
- `aes_dout` in 8: cipher result byte.

## Operation
- **States and transitions:**
  - IDLE: accept a request, then go to LOAD_PT.
  - LOAD_PT: 16 cycles, then GAP1.
  - GAP1: 1 cycle, then LOAD_KEY. Goes straight to START instead if the key is being reused.
  - LOAD_KEY: 16 cycles, then GAP2.
  - GAP2: 1 cycle, then START.
  - START: issue `CMD_ST`, then WAIT_OK.
  - WAIT_OK: on `aes_ok`, go to CAPTURE. On timeout, go to RESP.
  - CAPTURE: 16 cycles, then RESP.
  - RESP: on `rsp_ready`, go to IDLE.
- **On accept,** latch `req_text`, `req_key` and `reuse_eff = req_key_reuse && key_loaded`.
- **LOAD_PT:** `aes_cmd` = SP; `aes_din` = text byte 0..15, byte 0 first (LSB first).
- **LOAD_KEY:** `aes_cmd` = SK; `aes_din` = key bytes 0..15. Set `key_loaded` on the last key byte.
- **GAP1/GAP2:** `aes_cmd` = ID.
- **START:** `aes_cmd` = ST for exactly one cycle, issued only on a cycle with `aes_ready` = 1. Otherwise hold ID and stay in START.
- **WAIT_OK:**
  - Cycle counter starts at 0 on entry.
  - `aes_ok` = 1: capture `aes_dout` as byte 0 and go to CAPTURE.
  - Counter reaching `TIMEOUT_CYCLES` without `aes_ok`: go to RESP with `rsp_timeout` = 1 and `rsp_data` = 0.
- **CAPTURE:** bytes 1..15 are taken on the next 15 consecutive cycles. `aes_ok` is ignored there and in every state except WAIT_OK.
- **RESP:** `rsp_valid` = 1; `rsp_data`/`rsp_timeout` are stable until the handshake.
- **Outside load/start states:** `aes_cmd` = ID and `aes_din` = 0.
- **Outputs:** all registered except `req_ready` = (state == IDLE) && !`rst`.
- **`busy`:** no separate port; `req_ready` = 0 means busy.

## Timing
- **Reset values:** `req_ready` = 0 while `rst` = 1, and 1 on the first cycle after. `rsp_valid` = 0, `rsp_timeout` = 0, `rsp_data` = 0, `aes_cmd` = ID, `aes_din` = 0. `key_loaded` = 0; state = IDLE.
- **Full-load timeline.** Accept at cycle 0, then:
  - cycles 1–16: SP bytes
  - cycle 17: ID
  - cycles 18–33: SK bytes
  - cycle 34: ID
  - cycle 35: ST, when `aes_ready` = 1
- **Reuse timeline.** Accept at cycle 0, then:
  - cycles 1–16: SP bytes
  - cycle 17: ID
  - cycle 18: ST
- **Response:** if `aes_ok` is seen at cycle T, `rsp_valid` rises at T+16.
- **Back-to-back:** the next request can be accepted on the cycle after the `rsp_valid && rsp_ready` handshake.
- **`rst` in any state:** the next edge forces IDLE, `aes_cmd` = ID, `key_loaded` = 0 and `rsp_valid` = 0. Partial loads and captures are discarded.
- **`req_key_reuse` with `key_loaded` = 0:** silently ignored; the full key is loaded.
- **Timeout:** with `aes_ok` never asserted, `rsp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after entering WAIT_OK.

## Test plan
- **FIPS-197 vector.** Stimulus: `req_text` = 00112233445566778899aabbccddeeff, `req_key` = 000102030405060708090a0b0c0d0e0f; the cipher model returns 69c4e0d86a7b0430d8cdb78070b4c55a LSB-first. Required response:
  - `aes_din` = ff,ee,…,00 on cycles 1–16 and 0f,0e,…,00 on cycles 18–33.
  - ST on cycle 35.
  - `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a with `rsp_timeout` = 0.
- **Key reuse after the first request.** Stimulus: `req_key_reuse` = 1 on the second request. Required response: no SK cycle; ST on cycle 18; correct ciphertext.
- **Reuse right after reset.** Stimulus: `req_key_reuse` = 1 on the first request after reset. Required response: all 16 SK bytes are issued; ST on cycle 35.
- **Timeout.** Stimulus: `TIMEOUT_CYCLES` = 16, `aes_ok` held at 0. Required response: `rsp_valid` 17 cycles after entering WAIT_OK, with `rsp_timeout` = 1 and `rsp_data` = 0.
- **Backpressure.** Stimulus: `rsp_ready` low for 10 cycles, plus `aes_ready` low for 5 cycles at START. Required response:
  - `rsp_data` stays stable and `req_ready` stays 0 while backpressured.
  - ST is delayed exactly 5 cycles and issued once.
- **Reset mid-operation.** Stimulus: `rst` pulsed during LOAD_KEY byte 5. Required response:
  - `aes_cmd` = ID on the next cycle and `req_ready` = 1 afterwards.
  - A following reuse request performs a full key load.
